// File: rtl/monitor_trace_player_pkg.sv
// Shared types and entry-layout helpers for monitor_trace_player.
// An entry is packed as {delta, mask, values}, with channel 0 in the LSBs.
package monitor_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_FIRE,
    ST_DONE
  } state_e;

  function automatic int unsigned vals_w(int unsigned nch, int unsigned dw);
    return nch * dw;
  endfunction

  function automatic int unsigned mask_lsb(int unsigned nch, int unsigned dw);
    return nch * dw;
  endfunction

  function automatic int unsigned delta_lsb(int unsigned nch, int unsigned dw);
    return nch * dw + nch;
  endfunction

  function automatic int unsigned entry_w(int unsigned nch, int unsigned dw,
                                          int unsigned deltaw);
    return nch * dw + nch + deltaw;
  endfunction

  localparam int unsigned DEF_ENTRY_W = entry_w(2, 64, 32);

endpackage

// File: rtl/monitor_trace_player_trace_ram.sv
// Trace storage: simple dual-port RAM, one write port, one registered read port.
// Storage is deliberately not reset so a trace survives a reset of the player.
module trace_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port plus synchronous read of the presented address.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/monitor_trace_player.sv
// Timestamped event-trace player driving the stream monitor inputs.
// Optional feature macro: MONITOR_TRACE_PLAYER_LOOP_EN (replay trace until abort).
module monitor_trace_player
  import monitor_tb_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned DELTA_W = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_en,
  input  logic [$clog2(DEPTH)-1:0]               wr_addr,
  input  logic [DELTA_W+NUM_CH+NUM_CH*DATA_W-1:0] wr_data,
  input  logic [$clog2(DEPTH):0]                 num_entries,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic                                   ready,
  output logic [NUM_CH*DATA_W-1:0]               in_data,
  output logic [NUM_CH-1:0]                      in_new,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(DEPTH)-1:0]               event_idx,
  output logic [31:0]                            stall_cnt
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned VW        = vals_w(NUM_CH, DATA_W);
  localparam int unsigned MASK_LSB  = mask_lsb(NUM_CH, DATA_W);
  localparam int unsigned DELTA_LSB = delta_lsb(NUM_CH, DATA_W);
  localparam int unsigned EW        = entry_w(NUM_CH, DATA_W, DELTA_W);

`ifdef MONITOR_TRACE_PLAYER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_e              state_q;
  logic [AW-1:0]       idx_q;
  logic [AW:0]         num_q;
  logic [DELTA_W-1:0]  cnt_q;
  logic [NUM_CH-1:0]   in_new_q;
  logic [VW-1:0]       in_data_q;
  logic                done_q;
  logic [31:0]         stall_q;

  logic [EW-1:0]       rdata;
  logic [AW-1:0]       rd_addr;
  logic [DELTA_W-1:0]  r_delta;
  logic [NUM_CH-1:0]   r_mask;
  logic [VW-1:0]       r_vals;
  logic [VW-1:0]       r_data_m;
  logic [AW-1:0]       nxt_idx;
  logic [AW-1:0]       nxt2_idx;
  logic                is_last;
  logic                accept;
  logic                fire_wait;
  logic                fetch_fire;
  logic                next_imm;

  trace_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en && !busy),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rdata)
  );

  // Decode the RAM output word and derive sequencing conditions.
  always_comb begin
    r_delta  = rdata[DELTA_LSB +: DELTA_W];
    r_mask   = rdata[MASK_LSB +: NUM_CH];
    r_vals   = rdata[VW-1:0];
    r_data_m = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (r_mask[ch]) r_data_m[ch*DATA_W +: DATA_W] = r_vals[ch*DATA_W +: DATA_W];
    end
    is_last   = ((AW+1)'(idx_q) + (AW+1)'(1)) == num_q;
    nxt_idx   = is_last ? '0 : idx_q + AW'(1);
    nxt2_idx  = (((AW+1)'(nxt_idx) + (AW+1)'(1)) == num_q) ? '0 : nxt_idx + AW'(1);
    accept    = (state_q == ST_FIRE) && (ready || (in_new_q == '0));
    fire_wait = (state_q == ST_WAIT) &&
                (({1'b0, cnt_q} + (DELTA_W+1)'(1)) >= {1'b0, r_delta});
    fetch_fire = r_delta <= DELTA_W'(2);
    next_imm   = r_delta <= DELTA_W'(1);
  end

  // Read address: rdata always holds the entry the next state decision needs.
  // In WAIT it is the pending entry; from the fire decision onward it is the
  // following entry, so a zero/one delta can fire right after acceptance.
  always_comb begin
    rd_addr = '0;
    case (state_q)
      ST_FETCH: rd_addr = fetch_fire ? nxt_idx : idx_q;
      ST_WAIT:  rd_addr = fire_wait ? nxt_idx : idx_q;
      ST_FIRE:  rd_addr = (accept && next_imm) ? nxt2_idx : nxt_idx;
      default:  rd_addr = '0;
    endcase
  end

  // Playback FSM with registered channel outputs and status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      in_new_q  <= '0;
      in_data_q <= '0;
      done_q    <= 1'b0;
      stall_q   <= '0;
    end else if (abort) begin
      state_q   <= ST_IDLE;
      in_new_q  <= '0;
      in_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (start) begin
            stall_q <= '0;
            idx_q   <= '0;
            num_q   <= num_entries;
            if (num_entries == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
              done_q  <= 1'b0;
            end
          end
        end
        ST_FETCH: begin
          if (fetch_fire) begin
            state_q   <= ST_FIRE;
            in_new_q  <= r_mask;
            in_data_q <= r_data_m;
          end else begin
            state_q <= ST_WAIT;
            cnt_q   <= DELTA_W'(2);
          end
        end
        ST_WAIT: begin
          if (fire_wait) begin
            state_q   <= ST_FIRE;
            in_new_q  <= r_mask;
            in_data_q <= r_data_m;
          end else begin
            cnt_q <= cnt_q + DELTA_W'(1);
          end
        end
        ST_FIRE: begin
          if (accept) begin
            if (is_last && !LOOP_EN) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              in_new_q  <= '0;
              in_data_q <= '0;
            end else begin
              idx_q <= nxt_idx;
              if (next_imm) begin
                in_new_q  <= r_mask;
                in_data_q <= r_data_m;
              end else begin
                state_q   <= ST_WAIT;
                cnt_q     <= DELTA_W'(1);
                in_new_q  <= '0;
                in_data_q <= '0;
              end
            end
          end else if (stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_new    = in_new_q;
  assign in_data   = in_data_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_FIRE);
  assign done      = done_q;
  assign event_idx = idx_q;
  assign stall_cnt = stall_q;

endmodule
